// File: rtl/nested_loop_counter_if.sv
// Control, bound and index bundle for the nested loop counter.
// The master side drives start, abort, enable and the end numbers; the slave side is the counter.
interface nested_loop_counter_if #(
  parameter int NUM_LEVELS = 3,
  parameter int BITS       = 20
);
  logic                       start;
  logic                       abort;
  logic                       enable;
  logic [NUM_LEVELS*BITS-1:0] final_numbers;
  logic [NUM_LEVELS*BITS-1:0] cnt_q;
  logic [NUM_LEVELS-1:0]      last;
  logic                       busy;
  logic                       done;

  modport master (
    output start, abort, enable, final_numbers,
    input  cnt_q, last, busy, done
  );

  modport slave (
    input  start, abort, enable, final_numbers,
    output cnt_q, last, busy, done
  );
endinterface

// File: rtl/nested_loop_counter.sv
// Cascaded loop index generator: level 0 is innermost, and each level wraps at its own
// latched end number and carries into the next level. A pass ends when every level is last.
module nested_loop_counter #(
  parameter int NUM_LEVELS = 3,
  parameter int BITS       = 20,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic             clk,
  input logic             reset,
  nested_loop_counter_if.slave bus
);
  localparam logic [BITS-1:0]            ZERO_C     = BITS'(0);
  localparam logic [BITS-1:0]            ONE_C      = BITS'(1);
  localparam logic [NUM_LEVELS*BITS-1:0] CNT_ZERO_C = {NUM_LEVELS{ZERO_C}};
  localparam logic [NUM_LEVELS*BITS-1:0] END_RST_C  = {NUM_LEVELS{ONE_C}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [NUM_LEVELS*BITS-1:0] cnt_q, cnt_d;
  logic [NUM_LEVELS*BITS-1:0] end_q, end_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [NUM_LEVELS-1:0]      last_s;
  logic [NUM_LEVELS-1:0]      step_s;
  logic                       all_last_s;

  // Per-level terminal flags and the carry chain; a level steps only if all inner levels are last.
  always_comb begin
    logic carry_v;
    carry_v = 1'b1;
    last_s  = {NUM_LEVELS{1'b0}};
    step_s  = {NUM_LEVELS{1'b0}};
    for (int k = 0; k < NUM_LEVELS; k++) begin
      last_s[k] = (cnt_q[k*BITS +: BITS] == (end_q[k*BITS +: BITS] - ONE_C));
      step_s[k] = carry_v;
      carry_v   = carry_v & last_s[k];
    end
    all_last_s = carry_v;
  end

  // Control FSM next state, bound latching and counter stepping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // A zero end number would have no valid index, so it is treated as a single iteration.
          for (int k = 0; k < NUM_LEVELS; k++) begin
            if (bus.final_numbers[k*BITS +: BITS] == ZERO_C) begin
              end_d[k*BITS +: BITS] = ONE_C;
            end else begin
              end_d[k*BITS +: BITS] = bus.final_numbers[k*BITS +: BITS];
            end
          end
          cnt_d   = CNT_ZERO_C;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          cnt_d   = CNT_ZERO_C;
          state_d = ST_IDLE;
        end else if (bus.enable) begin
          for (int k = 0; k < NUM_LEVELS; k++) begin
            if (step_s[k]) begin
              if (last_s[k]) begin
                cnt_d[k*BITS +: BITS] = ZERO_C;
              end else begin
                cnt_d[k*BITS +: BITS] = cnt_q[k*BITS +: BITS] + ONE_C;
              end
            end else begin
              cnt_d[k*BITS +: BITS] = cnt_q[k*BITS +: BITS];
            end
          end
          if (all_last_s) begin
            done_d = 1'b1;
            if (CONTINUOUS) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO_C;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State, bounds, counters and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO_C;
      end_q   <= END_RST_C;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.cnt_q = cnt_q;
  assign bus.last  = last_s;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter: one-shot instance (bus_a) and continuous instance (bus_b).
module tb_nested_loop_counter;
  localparam int NL = 3;
  localparam int B  = 20;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  nested_loop_counter_if #(.NUM_LEVELS(NL), .BITS(B)) bus_a ();
  nested_loop_counter_if #(.NUM_LEVELS(NL), .BITS(B)) bus_b ();

  nested_loop_counter #(.NUM_LEVELS(NL), .BITS(B), .CONTINUOUS(1'b0)) u_once (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  nested_loop_counter #(.NUM_LEVELS(NL), .BITS(B), .CONTINUOUS(1'b1)) u_cont (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NL*B-1:0] pk(input int l2, input int l1, input int l0);
    return {B'(l2), B'(l1), B'(l0)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.enable = 1'b0; bus_a.final_numbers = pk(0, 0, 0);
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.enable = 1'b0; bus_b.final_numbers = pk(0, 0, 0);
    @(posedge clk); #1;
    total++;
    if ({bus_a.cnt_q, bus_a.busy, bus_a.done} !== {pk(0, 0, 0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_state: got=%h want=%h", {bus_a.cnt_q, bus_a.busy, bus_a.done}, {pk(0, 0, 0), 2'b00});
    end
    total++;
    if (bus_a.last !== 3'b111) begin
      bad++; $display("FAIL reset_last: got=%b want=%b", bus_a.last, 3'b111);
    end
    reset = 1'b0;
    bus_a.enable = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus_a.cnt_q, bus_a.busy, bus_a.done} !== {pk(0, 0, 0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL idle_ignores_enable: got=%h want=%h", {bus_a.cnt_q, bus_a.busy, bus_a.done}, {pk(0, 0, 0), 2'b00});
    end
  endtask

  task automatic test_full_pass();
    logic [NL*B+NL+1:0] got, exp;
    int e0, e1, e2;
    bus_a.final_numbers = pk(2, 3, 4);
    bus_a.enable = 1'b1;
    bus_a.start  = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    got = {bus_a.cnt_q, bus_a.last, bus_a.busy, bus_a.done};
    exp = {pk(0, 0, 0), 3'b000, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL full_entry: got=%h want=%h", got, exp); end
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      e0 = n % 4; e1 = (n / 4) % 3; e2 = (n / 12) % 2;
      got = {bus_a.cnt_q, bus_a.last, bus_a.busy, bus_a.done};
      exp = {pk(e2, e1, e0), (e2 == 1), (e1 == 2), (e0 == 3), (n != 24), (n == 24)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL full_step %0d: got=%h want=%h", n, got, exp); end
    end
    @(posedge clk); #1;
    got = {bus_a.cnt_q, bus_a.last, bus_a.busy, bus_a.done};
    exp = {pk(0, 0, 0), 3'b000, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL full_after: got=%h want=%h", got, exp); end
  endtask

  task automatic test_enable_toggle();
    logic [NL*B+1:0] got, exp;
    int n;
    bus_a.final_numbers = pk(2, 3, 4);
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start  = 1'b0;
    bus_a.enable = 1'b1;
    for (int j = 1; j <= 47; j++) begin
      @(posedge clk); #1;
      n = (j + 1) / 2;
      got = {bus_a.cnt_q, bus_a.busy, bus_a.done};
      exp = {pk((n / 12) % 2, (n / 4) % 3, n % 4), (j != 47), (j == 47)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL toggle_clock %0d: got=%h want=%h", j, got, exp); end
      bus_a.enable = ((j % 2) == 0);
    end
    bus_a.enable = 1'b1;
  endtask

  task automatic test_zero_end();
    logic [NL*B+NL+1:0] got, exp;
    int e0, e2;
    bus_a.final_numbers = pk(2, 0, 3);
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_a.final_numbers = pk(5, 5, 5);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      e0 = n % 3; e2 = (n / 3) % 2;
      got = {bus_a.cnt_q, bus_a.last, bus_a.busy, bus_a.done};
      exp = {pk(e2, 0, e0), (e2 == 1), 1'b1, (e0 == 2), (n != 6), (n == 6)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL zero_end_step %0d: got=%h want=%h", n, got, exp); end
    end
    @(posedge clk); #1;
    total++;
    if ({bus_a.busy, bus_a.done, bus_a.last} !== {1'b0, 1'b0, 3'b010}) begin
      bad++; $display("FAIL zero_end_after: got=%b want=%b", {bus_a.busy, bus_a.done, bus_a.last}, 5'b00010);
    end
  endtask

  task automatic test_continuous();
    logic [NL*B+NL+1:0] got, exp;
    bus_b.final_numbers = pk(1, 1, 2);
    bus_b.enable = 1'b1;
    bus_b.start  = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    got = {bus_b.cnt_q, bus_b.last, bus_b.busy, bus_b.done};
    exp = {pk(0, 0, 0), 3'b110, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL cont_entry: got=%h want=%h", got, exp); end
    for (int n = 1; n <= 8; n++) begin
      bus_b.start = (n == 3) || (n == 4);
      @(posedge clk); #1;
      got = {bus_b.cnt_q, bus_b.last, bus_b.busy, bus_b.done};
      exp = {pk(0, 0, n % 2), 1'b1, 1'b1, ((n % 2) == 1), 1'b1, ((n % 2) == 0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL cont_step %0d: got=%h want=%h", n, got, exp); end
    end
    bus_b.start = 1'b0;
    bus_b.abort = 1'b1;
    @(posedge clk); #1;
    bus_b.abort  = 1'b0;
    bus_b.enable = 1'b0;
    total++;
    if ({bus_b.cnt_q, bus_b.busy, bus_b.done} !== {pk(0, 0, 0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL cont_abort: got=%h want=%h", {bus_b.cnt_q, bus_b.busy, bus_b.done}, {pk(0, 0, 0), 2'b00});
    end
  endtask

  task automatic test_abort();
    bus_a.final_numbers = pk(2, 3, 4);
    bus_a.enable = 1'b1;
    bus_a.start  = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus_a.cnt_q !== pk(0, 1, 2)) begin
      bad++; $display("FAIL abort_pre: got=%h want=%h", bus_a.cnt_q, pk(0, 1, 2));
    end
    bus_a.abort = 1'b1;
    @(posedge clk); #1;
    bus_a.abort = 1'b0;
    total++;
    if ({bus_a.cnt_q, bus_a.busy, bus_a.done} !== {pk(0, 0, 0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL abort_clear: got=%h want=%h", {bus_a.cnt_q, bus_a.busy, bus_a.done}, {pk(0, 0, 0), 2'b00});
    end
    @(posedge clk); #1;
    total++;
    if ({bus_a.cnt_q, bus_a.busy, bus_a.done} !== {pk(0, 0, 0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL abort_idle: got=%h want=%h", {bus_a.cnt_q, bus_a.busy, bus_a.done}, {pk(0, 0, 0), 2'b00});
    end
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      total++;
      if ({bus_a.busy, bus_a.done} !== {(n != 24), (n == 24)}) begin
        bad++; $display("FAIL abort_restart %0d: got=%b want=%b", n, {bus_a.busy, bus_a.done}, {(n != 24), (n == 24)});
      end
    end
  endtask

  task automatic test_async_reset();
    bus_a.final_numbers = pk(2, 3, 4);
    bus_a.enable = 1'b1;
    bus_a.start  = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus_a.cnt_q !== pk(0, 1, 1)) begin
      bad++; $display("FAIL areset_pre: got=%h want=%h", bus_a.cnt_q, pk(0, 1, 1));
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus_a.cnt_q, bus_a.last, bus_a.busy, bus_a.done} !== {pk(0, 0, 0), 3'b111, 1'b0, 1'b0}) begin
      bad++; $display("FAIL areset_immediate: got=%h want=%h", {bus_a.cnt_q, bus_a.last, bus_a.busy, bus_a.done},
                      {pk(0, 0, 0), 3'b111, 2'b00});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      total++;
      if ({bus_a.busy, bus_a.done} !== 2'b00) begin
        bad++; $display("FAIL areset_no_done %0d: got=%b want=%b", n, {bus_a.busy, bus_a.done}, 2'b00);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_pass();
    test_enable_toggle();
    test_zero_end();
    test_continuous();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
